// File: rtl/fp_pkg.sv
// Shared field widths and operand types for the single-precision adder pipeline.
package fp_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;

  // IEEE-754 binary32 viewed as its three fields.
  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  // Mantissa with the hidden bit prepended.
  typedef logic [MAN_W:0] mant_ext_t;

  // The hidden bit is forced to 1 for every exponent, including zero and all-ones.
  function automatic mant_ext_t add_hidden(input logic [MAN_W-1:0] man);
    return {1'b1, man};
  endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational exponent compare and mantissa alignment.
// The operand with the smaller exponent is shifted right by the exponent
// difference; bits shifted past the LSB are dropped.
module fp_align_shift
  import fp_pkg::*;
(
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  input  mant_ext_t        full_a,
  input  mant_ext_t        full_b,
  output logic [EXP_W-1:0] exp_out,
  output mant_ext_t        aligned_a,
  output mant_ext_t        aligned_b
);

  logic [EXP_W-1:0] diff;

  // Pick the larger exponent and shift the other mantissa down to match it.
  always_comb begin
    diff      = '0;
    exp_out   = exp_a;
    aligned_a = full_a;
    aligned_b = full_b;
    if (exp_a > exp_b) begin
      diff      = exp_a - exp_b;
      exp_out   = exp_a;
      aligned_b = full_b >> diff;
    end else if (exp_b > exp_a) begin
      diff      = exp_b - exp_a;
      exp_out   = exp_b;
      aligned_a = full_a >> diff;
    end
  end

endmodule

// File: rtl/mask_alignment.sv
// First stage of the FP adder: slices both binary32 operands into fields,
// aligns their mantissas to the larger exponent and registers the result.
module mask_alignment
  import fp_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [31:0]      a,
  input  logic [31:0]      b,
  output logic             out_valid,
  output logic             sign_a,
  output logic             sign_b,
  output logic [EXP_W-1:0] exp_a,
  output logic [EXP_W-1:0] exp_b,
  output logic [MAN_W-1:0] man_a,
  output logic [MAN_W-1:0] man_b,
  output mant_ext_t        aligned_man_a,
  output mant_ext_t        aligned_man_b,
  output logic [EXP_W-1:0] exp_out
);

  fp32_t            op_a;
  fp32_t            op_b;
  logic [EXP_W-1:0] exp_out_c;
  mant_ext_t        aligned_a_c;
  mant_ext_t        aligned_b_c;

  assign op_a = fp32_t'(a);
  assign op_b = fp32_t'(b);

  fp_align_shift u_align (
    .exp_a     (op_a.exp),
    .exp_b     (op_b.exp),
    .full_a    (add_hidden(op_a.man)),
    .full_b    (add_hidden(op_b.man)),
    .exp_out   (exp_out_c),
    .aligned_a (aligned_a_c),
    .aligned_b (aligned_b_c)
  );

  // Valid follows the input every cycle; data only loads on an accepted pair and holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      sign_a        <= 1'b0;
      sign_b        <= 1'b0;
      exp_a         <= '0;
      exp_b         <= '0;
      man_a         <= '0;
      man_b         <= '0;
      aligned_man_a <= '0;
      aligned_man_b <= '0;
      exp_out       <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sign_a        <= op_a.sign;
        sign_b        <= op_b.sign;
        exp_a         <= op_a.exp;
        exp_b         <= op_b.exp;
        man_a         <= op_a.man;
        man_b         <= op_b.man;
        aligned_man_a <= aligned_a_c;
        aligned_man_b <= aligned_b_c;
        exp_out       <= exp_out_c;
      end
    end
  end

endmodule

// File: tb/tb_mask_alignment.sv
// Self-checking bench for mask_alignment: directed cases, reset behaviour,
// hold behaviour and a randomized back-to-back stream against a reference model.
module tb_mask_alignment;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        sign_a;
  logic        sign_b;
  logic [7:0]  exp_a;
  logic [7:0]  exp_b;
  logic [22:0] man_a;
  logic [22:0] man_b;
  logic [23:0] aligned_man_a;
  logic [23:0] aligned_man_b;
  logic [7:0]  exp_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] sign_a;
    logic [31:0] sign_b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [31:0] man_a;
    logic [31:0] man_b;
    logic [31:0] al_a;
    logic [31:0] al_b;
    logic [31:0] exp_out;
  } expect_t;

  expect_t lastExp;

  mask_alignment dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .a             (a),
    .b             (b),
    .out_valid     (out_valid),
    .sign_a        (sign_a),
    .sign_b        (sign_b),
    .exp_a         (exp_a),
    .exp_b         (exp_b),
    .man_a         (man_a),
    .man_b         (man_b),
    .aligned_man_a (aligned_man_a),
    .aligned_man_b (aligned_man_b),
    .exp_out       (exp_out)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference model: integer arithmetic straight from the alignment rules.
  function automatic expect_t model(input logic [31:0] ia, input logic [31:0] ib);
    expect_t e;
    int ea, eb, d;
    int fa, fb;
    ea = int'(ia[30:23]);
    eb = int'(ib[30:23]);
    fa = 8388608 + int'(ia[22:0]);
    fb = 8388608 + int'(ib[22:0]);
    e.sign_a = 32'(ia[31]);
    e.sign_b = 32'(ib[31]);
    e.exp_a  = 32'(ea);
    e.exp_b  = 32'(eb);
    e.man_a  = 32'(ia[22:0]);
    e.man_b  = 32'(ib[22:0]);
    e.al_a   = 32'(fa);
    e.al_b   = 32'(fb);
    if (ea >= eb) begin
      d         = ea - eb;
      e.exp_out = 32'(ea);
      e.al_b    = (d >= 24) ? 32'd0 : 32'(fb / (1 << d));
    end else begin
      d         = eb - ea;
      e.exp_out = 32'(eb);
      e.al_a    = (d >= 24) ? 32'd0 : 32'(fa / (1 << d));
    end
    return e;
  endfunction

  task automatic applyStimulus(input logic [31:0] ia, input logic [31:0] ib, input logic v);
    a        = ia;
    b        = ib;
    in_valid = v;
  endtask

  task automatic checkFields(input string tag, input expect_t e, input logic vexp);
    checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'(vexp));
    checkOutput({tag, ".sign_a"},    32'(sign_a), e.sign_a);
    checkOutput({tag, ".sign_b"},    32'(sign_b), e.sign_b);
    checkOutput({tag, ".exp_a"},     32'(exp_a), e.exp_a);
    checkOutput({tag, ".exp_b"},     32'(exp_b), e.exp_b);
    checkOutput({tag, ".man_a"},     32'(man_a), e.man_a);
    checkOutput({tag, ".man_b"},     32'(man_b), e.man_b);
    checkOutput({tag, ".aligned_a"}, 32'(aligned_man_a), e.al_a);
    checkOutput({tag, ".aligned_b"}, 32'(aligned_man_b), e.al_b);
    checkOutput({tag, ".exp_out"},   32'(exp_out), e.exp_out);
  endtask

  task automatic checkAllZero(input string tag);
    expect_t z;
    z = '{default: 32'd0};
    checkFields(tag, z, 1'b0);
  endtask

  // Drive one valid pair and check it one cycle later against the model.
  task automatic runPair(input string tag, input logic [31:0] ia, input logic [31:0] ib);
    @(negedge clk);
    applyStimulus(ia, ib, 1'b1);
    @(posedge clk);
    #1;
    lastExp = model(ia, ib);
    checkFields(tag, lastExp, 1'b1);
  endtask

  task automatic runDirected(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                             input logic [7:0] eo, input logic [23:0] xa, input logic [23:0] xb);
    runPair(tag, ia, ib);
    checkOutput({tag, ".const_exp_out"}, 32'(exp_out), 32'(eo));
    checkOutput({tag, ".const_al_a"},    32'(aligned_man_a), 32'(xa));
    checkOutput({tag, ".const_al_b"},    32'(aligned_man_b), 32'(xb));
  endtask

  // Main sequence: reset, directed vectors, hold, async reset, random stream.
  initial begin
    logic [31:0] ra, rb;
    rst_n = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0);
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    runDirected("d1", 32'h40400000, 32'h3F800000, 8'h80, 24'hC00000, 24'h400000);
    runDirected("d2", 32'h3F800000, 32'h40400000, 8'h80, 24'h400000, 24'hC00000);
    runDirected("d3", 32'h3FC00000, 32'hBF800000, 8'h7F, 24'hC00000, 24'h800000);
    checkOutput("d3.const_sign_b", 32'(sign_b), 32'd1);
    runDirected("d4", 32'h4B000000, 32'h3FFFFFFF, 8'h96, 24'h800000, 24'h000001);
    runDirected("d5", 32'h7F000000, 32'h00000000, 8'hFE, 24'h800000, 24'h000000);
    runDirected("d6", 32'h7F800001, 32'h7F800001, 8'hFF, 24'h800001, 24'h800001);

    // Idle cycle: data must hold the last accepted pair, valid drops.
    @(negedge clk);
    applyStimulus(32'h12345678, 32'h9ABCDEF0, 1'b0);
    @(posedge clk);
    #1;
    checkFields("hold", lastExp, 1'b0);

    // Asynchronous reset in the middle of a valid stream.
    runPair("pre_rst", 32'h41200000, 32'h40A00000);
    @(negedge clk);
    applyStimulus(32'h42000000, 32'h3E000000, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkAllZero("async_rst");
    @(posedge clk);
    #1;
    checkAllZero("rst_held");
    @(negedge clk);
    rst_n = 1'b1;
    runPair("post_rst", 32'hC1100000, 32'h40800000);

    // Randomized back-to-back stream; half the pairs get nearby exponents.
    for (int i = 0; i < 2048; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 2 == 0)
        rb[30:23] = ra[30:23] + 8'($urandom_range(0, 60)) - 8'd30;
      runPair("rand", ra, rb);
    end

    @(negedge clk);
    applyStimulus(32'h0, 32'h0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("final_idle.out_valid", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
